// File: rtl/axi_2p_master.sv
// rtl/axi_2p_master.sv - AXI4 single-burst INCR master driven from a command port
//
// Ports:
//   s_aclk, s_aresetn          clock, asynchronous active-low reset
//   cmd_*                      command port: write/read select, start address, len (beats-1)
//   wr_data/wr_strb/wr_valid/wr_ready   write beat stream (pulled during W phase)
//   rd_data/rd_last/rd_valid/rd_ready   read beat stream (pushed during R phase)
//   done/err/busy              completion pulse, error (qualified by done), activity flag
//   m_axi_aw*/w*/b*/ar*/r*     AXI4 master channels
module axi_2p_master #(
  parameter int  G_DATAWIDTH = 32,
  parameter int  G_ADDRWIDTH = 12,
  parameter int  G_ID_WIDTH  = 4,
  parameter int  G_ID        = 0,
  localparam int G_WEWIDTH   = G_DATAWIDTH / 8
) (
  input  logic                   s_aclk,
  input  logic                   s_aresetn,
  // command port
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [G_ADDRWIDTH-1:0] cmd_addr,
  input  logic [7:0]             cmd_len,
  // write beat stream
  input  logic [G_DATAWIDTH-1:0] wr_data,
  input  logic [G_WEWIDTH-1:0]   wr_strb,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  // read beat stream
  output logic [G_DATAWIDTH-1:0] rd_data,
  output logic                   rd_last,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  // status
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  // AXI write address
  output logic [G_ID_WIDTH-1:0]  m_axi_awid,
  output logic [G_ADDRWIDTH-1:0] m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  // AXI write data
  output logic [G_DATAWIDTH-1:0] m_axi_wdata,
  output logic [G_WEWIDTH-1:0]   m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  // AXI write response
  input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  // AXI read address
  output logic [G_ID_WIDTH-1:0]  m_axi_arid,
  output logic [G_ADDRWIDTH-1:0] m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  // AXI read data
  input  logic [G_ID_WIDTH-1:0]  m_axi_rid,
  input  logic [G_DATAWIDTH-1:0] m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WRESP = 3'd3;
  localparam logic [2:0] S_RADDR = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;

  localparam logic [2:0]            C_SIZE = 3'($clog2(G_WEWIDTH));
  localparam logic [G_ID_WIDTH-1:0] C_ID   = G_ID_WIDTH'(G_ID);

  logic [2:0]             state;
  logic [G_ADDRWIDTH-1:0] addr_q;
  logic [7:0]             len_q;
  logic [7:0]             cnt_q;
  logic                   err_acc;

  logic cnt_last;
  logic w_hs;
  logic r_hs;
  logic b_bad;
  logic r_bad;

  // rid is not checked; only one transaction is ever outstanding
  logic [G_ID_WIDTH-1:0] unused_rid;
  assign unused_rid = m_axi_rid;

  // Compare before increment so len=255 yields 256 beats with an 8-bit counter
  assign cnt_last = (cnt_q == len_q);
  assign w_hs     = (state == S_WDATA) && wr_valid && m_axi_wready;
  assign r_hs     = (state == S_RDATA) && m_axi_rvalid && rd_ready;
  assign b_bad    = (m_axi_bresp != 2'b00) || (m_axi_bid != C_ID);
  // Early or missing rlast both count as a protocol error
  assign r_bad    = (m_axi_rresp != 2'b00) || (m_axi_rlast != cnt_last);

  // Held low during reset even though the state register already reads IDLE
  assign cmd_ready = (state == S_IDLE) && s_aresetn;
  assign busy      = (state != S_IDLE);

  assign m_axi_awid    = C_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = C_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state == S_WADDR);

  // W channel is a combinational pass-through of the write stream
  assign m_axi_wvalid = (state == S_WDATA) && wr_valid;
  assign wr_ready     = (state == S_WDATA) && m_axi_wready;
  assign m_axi_wdata  = (state == S_WDATA) ? wr_data : '0;
  assign m_axi_wstrb  = (state == S_WDATA) ? wr_strb : '0;
  assign m_axi_wlast  = (state == S_WDATA) && cnt_last;

  assign m_axi_bready = (state == S_WRESP);

  assign m_axi_arid    = C_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = C_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state == S_RADDR);

  // R channel is a combinational pass-through to the read stream
  assign rd_valid     = (state == S_RDATA) && m_axi_rvalid;
  assign m_axi_rready = (state == S_RDATA) && rd_ready;
  assign rd_data      = (state == S_RDATA) ? m_axi_rdata : '0;
  assign rd_last      = (state == S_RDATA) && cnt_last;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_acc <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            cnt_q   <= '0;
            err_acc <= 1'b0;
            state   <= cmd_write ? S_WADDR : S_RADDR;
          end
        end
        S_WADDR: begin
          if (m_axi_awready) state <= S_WDATA;
        end
        S_WDATA: begin
          if (w_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_last) state <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (m_axi_bvalid) begin
            done  <= 1'b1;
            err   <= err_acc | b_bad;
            state <= S_IDLE;
          end
        end
        S_RADDR: begin
          if (m_axi_arready) state <= S_RDATA;
        end
        S_RDATA: begin
          if (r_hs) begin
            cnt_q   <= cnt_q + 8'd1;
            err_acc <= err_acc | r_bad;
            if (m_axi_rlast || cnt_last) begin
              done  <= 1'b1;
              err   <= err_acc | r_bad;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_2p_master.md
Name: axi_2p_master

Overview:
- AXI4 burst initiator (master) that issues single INCR burst transactions from a simple command port.
- Write data is pulled from a valid/ready stream; read data is pushed out on a valid/ready stream.
- Drives the s_axi_* slave port of the team's AXI block-memory slaves, e.g. for DMA-style fills and readback in testbenches and subsystems.
- One outstanding transaction at a time.

Parameters:
G_DATAWIDTH, 32, AXI data width in bits (multiple of 8)
G_ADDRWIDTH, 12, AXI byte-address width
G_ID_WIDTH, 4, AXI ID width
G_ID, 0, constant ID driven on awid/arid
G_WEWIDTH, G_DATAWIDTH/8, strobe width (derived, not overridden)

Ports:
s_aclk  in  1  clock
s_aresetn  in  1  reset; asynchronous assert, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  G_ADDRWIDTH  start byte address, aligned to G_WEWIDTH
cmd_len  in  8  beats-1 (AXI len encoding)
wr_data  in  G_DATAWIDTH  write beat data
wr_strb  in  G_WEWIDTH  write beat strobes
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat consumed
rd_data  out  G_DATAWIDTH  read beat data
rd_last  out  1  final beat of burst
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat accept
done  out  1  one-cycle pulse at transaction end
err  out  1  qualified by done; any non-OKAY resp or rlast mismatch
busy  out  1  high from command accept until done
m_axi_aw{id,addr,len,size,burst,valid}, m_axi_awready  out/in  per AXI4  write address channel
m_axi_w{data,strb,last,valid}, m_axi_wready  out/in  per AXI4  write data channel
m_axi_b{id,resp,valid}, m_axi_bready  in/out  per AXI4  write response channel
m_axi_ar{id,addr,len,size,burst,valid}, m_axi_arready  out/in  per AXI4  read address channel
m_axi_r{id,data,resp,last,valid}, m_axi_rready  in/out  per AXI4  read data channel

Behaviour:
- Reset (s_aresetn low, async): FSM=IDLE. All valids, bready, rready, wr_ready, done, err and busy are 0. cmd_ready=0 while reset is asserted. Address, len and data outputs are 0.
- Constant outputs: awsize/arsize=$clog2(G_WEWIDTH), awburst/arburst=2'b01 (INCR), awid/arid=G_ID.
- 4 KB crossing and misalignment are the caller's responsibility; the block does not split bursts.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE: cmd_ready=1. On accept, register addr/len/write, clear the beat counter and error flag, set busy, and go to WADDR or RADDR the next cycle.
- WADDR: awvalid=1 with registered addr/len. Hold stable until awready; then go to WDATA. AW strictly precedes W.
- WDATA: wvalid=wr_valid, wr_ready=wready (combinational pass-through), wdata/wstrb=wr_data/wr_strb.
  - wlast=1 when beat counter==len.
  - Counter increments on each wvalid&wready.
  - On the last-beat handshake, go to WRESP.
- WRESP: bready=1. On bvalid, err flag |= (bresp!=0) | (bid!=G_ID); pulse done and return to IDLE.
- RADDR: arvalid=1 until arready; then go to RDATA.
- RDATA: rd_valid=rvalid, rready=rd_ready, rd_data=rdata (combinational). rd_last=1 on counter==len.
  - On each handshake: err |= (rresp!=0); counter increments.
  - Burst ends on the first handshake where rlast=1 OR counter==len.
  - If rlast differs from (counter==len) on any handshake, set err.
  - At burst end: done pulse, return to IDLE.
- done and err are registered. They assert the cycle after the final B/R handshake, for exactly 1 cycle. busy falls in the same cycle done asserts. cmd_ready rises in that cycle.
- Counter is 8 bits; len=255 gives 256 beats without wrap issues (compare before increment).
- Back-to-back: a new command may be accepted in the done cycle.
- Async reset mid-burst abandons the transaction immediately; no draining.

Test Plan:
- Write addr=0x010, len=0, data 0xA5A5A5A5, strb 0xF, slave awready delayed 3 cycles -> awaddr=0x010, awlen=0, awsize=2, single beat with wlast=1, done=1/err=0 one cycle after bvalid.
- Write len=3 to 0x100, data 1..4, wr_valid gapped every other cycle, wready low 2 cycles mid-burst -> exactly 4 W handshakes, wlast only on beat 4, data order 1,2,3,4.
- Read len=3 from 0x100 against the axi_2p memory slave after the prior write, rd_ready toggling -> rd_data 1,2,3,4, rd_last on beat 4, done with err=0.
- Slave returns bresp=2'b10 -> done with err=1; next command is accepted normally and completes with err=0.
- Read len=7 with slave asserting rlast on beat 4 -> transaction ends after 4 beats, done with err=1, FSM returns to IDLE.
- s_aresetn low during WDATA beat 2 of 4 -> wvalid, awvalid, busy and wr_ready drop to 0 immediately. After release, cmd_ready=1 and a fresh len=0 read completes.
